// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB low/full-speed transmit encoder.
// Optional CRC-16 support is controlled by the USB_TX_CRC16_EN macro.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    LOAD    = 3'd2,
    SEND    = 3'd3,
`ifdef USB_TX_CRC16_EN
    CRC     = 3'd4,
`endif
    EOP_SE0 = 3'd5,
    EOP_J   = 3'd6,
    DONE    = 3'd7
  } tx_state_e;

  localparam logic [7:0]  SYNC_BYTE     = 8'h80;
  localparam logic [1:0]  LINE_J        = 2'b10;
  localparam logic [1:0]  LINE_K        = 2'b01;
  localparam logic [1:0]  LINE_SE0      = 2'b00;
  localparam logic [15:0] CRC_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC_INIT      = 16'hFFFF;

  localparam logic [2:0]  STUFF_LIMIT   = 3'd6;
  localparam logic [4:0]  SYNC_LEN      = 5'd8;
  localparam logic [4:0]  CRC_LEN       = 5'd16;
  localparam logic [4:0]  EOP_SE0_LEN   = 5'd2;

  // NRZI: a 0 toggles between J and K, a 1 holds the current level.
  function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic bit_val);
    if (bit_val) begin
      return line;
    end
    return (line == LINE_J) ? LINE_K : LINE_J;
  endfunction

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_val);
    logic feedback;
    feedback = crc[0] ^ bit_val;
    return feedback ? ((crc >> 1) ^ CRC_POLY_REFL) : (crc >> 1);
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Free-running counter with synchronous clear, rolling over at a programmable value.
// Used as the bit-period timer of the USB transmit encoder.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = (count_q == rollover_val) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign rollover_flag = count_enable && (count_q == rollover_val);

endmodule

// File: rtl/usb_tx_encoder.sv
// USB packet transmitter: SYNC, FIFO data bytes, optional CRC-16, bit stuffing, NRZI, EOP.
// Define USB_TX_CRC16_EN to append the CRC-16/USB of the data bytes before EOP.
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int NUMBITS      = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               tx_start,
  input  logic               fifo_empty,
  input  logic [NUMBITS-1:0] fifo_r_data,
  output logic               fifo_r_enable,
  output logic               d_plus,
  output logic               d_minus,
  output logic               tx_busy,
  output logic               tx_done
);
  import usb_tx_pkg::*;

  localparam int               CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [4:0]       DATA_BITS = 5'(NUMBITS);

  tx_state_e          state_q, state_d;
  logic [1:0]         line_q, line_d;
  logic [NUMBITS-1:0] shift_q, shift_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [2:0]         ones_q, ones_d;
`ifdef USB_TX_CRC16_EN
  logic [15:0]        crc_q, crc_d;
  logic               crc_feed;
`endif

  logic       bit_end;
  logic       timer_clear;
  logic       timer_en;
  logic       start_ok;
  logic       stuff_due;
  logic       tx_launch;
  logic       tx_bit;
  logic [7:0] sync_shifted;

  assign start_ok    = tx_start && !fifo_empty;
  assign stuff_due   = (ones_q == STUFF_LIMIT);
  assign timer_clear = (state_q == IDLE);
  assign timer_en    = (state_q != IDLE);

  flex_counter #(
    .NUM_CNT_BITS(CNT_W)
  ) bit_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (timer_clear),
    .count_enable (timer_en),
    .rollover_val (BIT_LAST),
    .rollover_flag(bit_end)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      line_q    <= LINE_J;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      ones_q    <= '0;
`ifdef USB_TX_CRC16_EN
      crc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ones_q    <= ones_d;
`ifdef USB_TX_CRC16_EN
      crc_q     <= crc_d;
`endif
    end
  end

  // A pending stuff bit always takes priority over any section boundary.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (bit_end && (bit_cnt_q == SYNC_LEN)) begin
          state_d = LOAD;
        end
      end
      LOAD: state_d = SEND;
      SEND: begin
        if (bit_end && !stuff_due && (bit_cnt_q == DATA_BITS)) begin
          if (!fifo_empty) begin
            state_d = LOAD;
          end else begin
`ifdef USB_TX_CRC16_EN
            state_d = CRC;
`else
            state_d = EOP_SE0;
`endif
          end
        end
      end
`ifdef USB_TX_CRC16_EN
      CRC: begin
        if (bit_end && !stuff_due && (bit_cnt_q == CRC_LEN)) begin
          state_d = EOP_SE0;
        end
      end
`endif
      EOP_SE0: begin
        if (bit_end && (bit_cnt_q == EOP_SE0_LEN)) begin
          state_d = EOP_J;
        end
      end
      EOP_J: begin
        if (bit_end) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The next bit is launched onto the line on the edge that starts its period;
  // the first bit of each byte comes straight from the FIFO head so LOAD costs no line time.
  always_comb begin
    line_d       = line_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    ones_d       = ones_q;
    tx_launch    = 1'b0;
    tx_bit       = 1'b1;
    sync_shifted = SYNC_BYTE >> bit_cnt_q;
`ifdef USB_TX_CRC16_EN
    crc_d        = crc_q;
    crc_feed     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        line_d = LINE_J;
        ones_d = '0;
        if (start_ok) begin
          tx_launch = 1'b1;
          tx_bit    = SYNC_BYTE[0];
          bit_cnt_d = 5'd1;
`ifdef USB_TX_CRC16_EN
          crc_d     = CRC_INIT;
`endif
        end
      end
      SYNC: begin
        if (bit_end) begin
          tx_launch = 1'b1;
          if (bit_cnt_q == SYNC_LEN) begin
            tx_bit    = fifo_r_data[0];
            bit_cnt_d = 5'd1;
`ifdef USB_TX_CRC16_EN
            crc_feed  = 1'b1;
`endif
          end else begin
            tx_bit    = sync_shifted[0];
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      LOAD: shift_d = fifo_r_data;
      SEND: begin
        if (bit_end) begin
          if (stuff_due) begin
            tx_launch = 1'b1;
            tx_bit    = 1'b0;
          end else if (bit_cnt_q == DATA_BITS) begin
            if (!fifo_empty) begin
              tx_launch = 1'b1;
              tx_bit    = fifo_r_data[0];
              bit_cnt_d = 5'd1;
`ifdef USB_TX_CRC16_EN
              crc_feed  = 1'b1;
`endif
            end else begin
`ifdef USB_TX_CRC16_EN
              tx_launch = 1'b1;
              tx_bit    = ~crc_q[0];
              bit_cnt_d = 5'd1;
`else
              line_d    = LINE_SE0;
              ones_d    = '0;
              bit_cnt_d = 5'd1;
`endif
            end
          end else begin
            tx_launch = 1'b1;
            tx_bit    = shift_q[1];
            shift_d   = {shift_q[0], shift_q[NUMBITS-1:1]};
            bit_cnt_d = bit_cnt_q + 5'd1;
`ifdef USB_TX_CRC16_EN
            crc_feed  = 1'b1;
`endif
          end
        end
      end
`ifdef USB_TX_CRC16_EN
      CRC: begin
        if (bit_end) begin
          if (stuff_due) begin
            tx_launch = 1'b1;
            tx_bit    = 1'b0;
          end else if (bit_cnt_q == CRC_LEN) begin
            line_d    = LINE_SE0;
            ones_d    = '0;
            bit_cnt_d = 5'd1;
          end else begin
            tx_launch = 1'b1;
            tx_bit    = ~crc_q[1];
            crc_d     = crc_q >> 1;
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
`endif
      EOP_SE0: begin
        line_d = LINE_SE0;
        if (bit_end) begin
          if (bit_cnt_q == EOP_SE0_LEN) begin
            line_d = LINE_J;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      EOP_J:   line_d = LINE_J;
      DONE:    line_d = LINE_J;
      default: line_d = LINE_J;
    endcase

    if (tx_launch) begin
      line_d = nrzi_next((state_q == IDLE) ? LINE_J : line_q, tx_bit);
      ones_d = tx_bit ? (ones_q + 3'd1) : 3'd0;
    end
`ifdef USB_TX_CRC16_EN
    if (crc_feed) begin
      crc_d = crc16_step(crc_q, tx_bit);
    end
`endif
  end

  always_comb begin
    fifo_r_enable      = (state_q == LOAD);
    tx_busy            = (state_q != IDLE);
    tx_done            = (state_q == DONE);
    {d_plus, d_minus}  = line_q;
  end

endmodule

// File: doc/usb_tx_encoder.md
USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8: clk cycles per USB bit period, legal values 2 to 255.
REQ-002 SHALL have parameter NUMBITS, default 8: FIFO data width in bits.
REQ-003 SHALL have port clk  input  1: sole clock, rising edge.
REQ-004 SHALL have port n_rst  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port tx_start  input  1: one-cycle request to send one packet.
REQ-006 SHALL have port fifo_empty  input  1: TX FIFO holds no bytes.
REQ-007 SHALL have port fifo_r_data  input  NUMBITS: FIFO head byte, valid whenever fifo_empty=0.
REQ-008 SHALL have port fifo_r_enable  output  1: one-cycle pop of the FIFO head byte.
REQ-009 SHALL have port d_plus  output  1: USB D+ line.
REQ-010 SHALL have port d_minus  output  1: USB D- line.
REQ-011 SHALL have port tx_busy  output  1: a packet is in progress.
REQ-012 SHALL have port tx_done  output  1: one-cycle pulse at the end of the packet.

Function
REQ-013 SHALL use states IDLE, SYNC, LOAD, SEND, CRC, EOP_SE0, EOP_J and DONE.
REQ-014 IDLE SHALL go to SYNC on tx_start=1 with fifo_empty=0; tx_start with fifo_empty=1 SHALL be ignored.
REQ-015 SYNC SHALL send the byte 0x80 LSB first (seven 0 bits, then one 1 bit), starting on the cycle after tx_start.
REQ-016 LOAD SHALL assert fifo_r_enable for exactly one cycle, capture fifo_r_data into the shift register in that same cycle, then go to SEND.
REQ-017 SEND SHALL send 8 bits LSB first, one bit every CLKS_PER_BIT cycles.
REQ-018 At each byte boundary, SEND SHALL go to LOAD if fifo_empty=0, else to CRC if USB_TX_CRC16_EN is defined, else to EOP_SE0.
REQ-019 After six consecutive 1 bits, including SYNC bits and bits already stuffed, the block SHALL insert one 0 bit without consuming data; this SHALL also apply after the final data or CRC bit.
REQ-020 Line encoding SHALL be NRZI: a 0 bit toggles the line between J (d_plus=1, d_minus=0) and K (d_plus=0, d_minus=1); a 1 bit holds the line.
REQ-021 EOP_SE0 SHALL drive d_plus=0 and d_minus=0 for 2 bit periods; EOP_J SHALL then drive J for 1 bit period.
REQ-022 DONE SHALL pulse tx_done for one cycle and return to IDLE.
REQ-023 tx_busy SHALL be 1 in every state except IDLE.
REQ-024 tx_start SHALL be ignored while tx_busy=1.
REQ-025 Each bit period SHALL be timed by a counter that rolls over at CLKS_PER_BIT-1 and restarts at SYNC entry.

Reset
REQ-026 On n_rst=0 at a rising edge, the block SHALL enter IDLE, drive J on the line, clear tx_busy, tx_done and fifo_r_enable, and clear the stuff count, shift register and CRC register.
REQ-027 A reset in the middle of a packet SHALL abort it; no EOP SHALL be sent and no further FIFO pops SHALL occur.

Configuration
REQ-028 With macro USB_TX_CRC16_EN defined, the block SHALL compute CRC-16/USB over all data bytes (polynomial 0x8005, reflected, initial value 0xFFFF, final value inverted) and send the 16 CRC bits LSB first in state CRC, with stuffing applied.
REQ-029 With USB_TX_CRC16_EN undefined, the CRC state and CRC register SHALL be absent, and SEND SHALL go directly to EOP_SE0.

Structure
REQ-030 Package usb_tx_pkg SHALL hold the state enum, SYNC_BYTE=8'h80, the J/K/SE0 line encodings, CRC_POLY_REFL=16'hA001 and CRC_INIT=16'hFFFF.
REQ-031 The bit timer SHALL be one flex_counter instance; all other logic SHALL be inline.

Verification (CLKS_PER_BIT=8)
REQ-032 Hold n_rst=0 for 2 cycles -> d_plus=1, d_minus=0, tx_busy=0, fifo_r_enable=0.
REQ-033 FIFO={0x00}, CRC off, tx_start -> line reads KJKJKJKK, then 8 toggles, then 2 periods SE0, then J; tx_done at cycle 152 after the first SYNC cycle; exactly 1 pop.
REQ-034 FIFO={0xFF}, CRC off -> one stuff bit inserted after the 5th data bit; 17 bit periods before SE0.
REQ-035 FIFO={0x12,0x34}, plus a second tx_start mid-packet -> exactly 2 fifo_r_enable pulses; a single packet; tx_done pulses once.
REQ-036 With CRC on, FIFO="123456789" -> CRC bytes 0xC8 then 0xB4 are sent after the data.
REQ-037 Reset asserted during the 2nd data byte -> J on the line the next cycle; no tx_done; no further pops.
